// File: rtl/seg_pkg.sv
// seg_pkg: shared types and helpers for the 7-segment display blocks.
// The decoder and scan controllers agree on the nibble type defined here.
package seg_pkg;

   localparam int SEG_NIBBLE_W   = 4;
   localparam int SEG_MAX_DIGITS = 8;

   typedef logic [SEG_NIBBLE_W-1:0] seg_digit_t;

   // Width of an index able to address n items (never below 1 bit).
   function automatic int seg_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // All-off anode pattern for an n-digit active-low display.
   function automatic logic [SEG_MAX_DIGITS-1:0] seg_an_off(input int n);
      seg_an_off = '0;
      for (int i = 0; i < SEG_MAX_DIGITS; i++) begin
         if (i < n) seg_an_off[i] = 1'b1;
      end
   endfunction

endpackage

// File: rtl/seg_prescaler.sv
// seg_prescaler: free-running 0..DIV-1 counter with a terminal-count flag.
// Shared by display blocks that need a slot/refresh timebase.
module seg_prescaler #(
   parameter int unsigned DIV = 50000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   output logic [$clog2(DIV)-1:0] cnt_o,
   output logic                   tc_o
);

   localparam int CNT_W = $clog2(DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Terminal count decode and wrap-around next state.
   always_comb begin
      tc_o  = (cnt_q == CNT_W'(DIV - 1));
      cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display with frame-coherent double buffering.
// Optional feature macro: SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD_CYC   = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [SEG_NIBBLE_W*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]             dp_in,
   input  logic                              load,
   input  logic                              blank,
   output logic [SEG_NIBBLE_W-1:0]           x_out,
   output logic [NUM_DIGITS-1:0]             an_n,
   output logic                              dp_n,
   output logic                              frame_pulse
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = seg_idx_w(NUM_DIGITS);
   localparam int VAL_W = SEG_NIBBLE_W * NUM_DIGITS;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = NUM_DIGITS'(seg_an_off(NUM_DIGITS));

   logic [CNT_W-1:0]      cnt;
   logic                  tc;
   logic                  frame_end;

   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [VAL_W-1:0]      disp_val_q, disp_val_d;
   logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
   logic [VAL_W-1:0]      pend_val_q, pend_val_d;
   logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
   logic                  pend_v_q, pend_v_d;

   seg_digit_t            x_out_q, x_out_d;
   logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
   logic                  dp_n_q, dp_n_d;
   logic                  fp_q, fp_d;

   logic [NUM_DIGITS-1:0] lit_mask;

   seg_prescaler #(.DIV(REFRESH_DIV)) u_presc (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt_o (cnt),
      .tc_o  (tc)
   );

   assign frame_end = tc && (idx_q == IDX_W'(NUM_DIGITS - 1));

`ifdef SEG_SCAN_LZB_EN
   logic lz_seen;

   // Digits above the highest non-zero nibble stay dark unless their
   // decimal point is requested; digit 0 always shows.
   always_comb begin
      lit_mask = '0;
      lz_seen  = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (disp_val_q[i*SEG_NIBBLE_W +: SEG_NIBBLE_W] != '0) lz_seen = 1'b1;
         lit_mask[i] = lz_seen | disp_dp_q[i] | (i == 0);
      end
   end
`else
   assign lit_mask = '1;
`endif

   // Digit index, pending buffer and frame-boundary display update.
   always_comb begin
      idx_d      = idx_q;
      disp_val_d = disp_val_q;
      disp_dp_d  = disp_dp_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      pend_v_d   = pend_v_q;

      if (tc) idx_d = frame_end ? '0 : idx_q + IDX_W'(1);

      if (load) begin
         pend_val_d = value;
         pend_dp_d  = dp_in;
         pend_v_d   = 1'b1;
      end

      // A load landing on the boundary bypasses the pending buffer so the
      // new frame shows it immediately.
      if (frame_end) begin
         if (load) begin
            disp_val_d = value;
            disp_dp_d  = dp_in;
         end else if (pend_v_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
         end
         pend_v_d = 1'b0;
      end
   end

   // Registered pin outputs derived from this cycle's slot position.
   always_comb begin
      x_out_d = disp_val_q[{idx_q, 2'b00} +: SEG_NIBBLE_W];
      an_n_d  = AN_OFF;
      dp_n_d  = ~disp_dp_q[idx_q];
      fp_d    = frame_end;
      if (!blank && (cnt >= CNT_W'(GUARD_CYC)) && lit_mask[idx_q]) begin
         an_n_d = ~(NUM_DIGITS'(1) << idx_q);
      end
      if (blank) dp_n_d = 1'b1;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= '0;
         disp_val_q <= '0;
         disp_dp_q  <= '0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         pend_v_q   <= 1'b0;
         x_out_q    <= '0;
         an_n_q     <= AN_OFF;
         dp_n_q     <= 1'b1;
         fp_q       <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         disp_val_q <= disp_val_d;
         disp_dp_q  <= disp_dp_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         pend_v_q   <= pend_v_d;
         x_out_q    <= x_out_d;
         an_n_q     <= an_n_d;
         dp_n_q     <= dp_n_d;
         fp_q       <= fp_d;
      end
   end

   assign x_out       = x_out_q;
   assign an_n        = an_n_q;
   assign dp_n        = dp_n_q;
   assign frame_pulse = fp_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized and directed bench for seg_scan_ctrl with a
// time-position reference model (slot/offset derived from cycles since reset).
module tb_seg_scan_ctrl;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int G  = 2;
   localparam int F  = ND * RD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic        load = 1'b0;
   logic        blank = 1'b0;
   logic [3:0]  x_out;
   logic [3:0]  an_n;
   logic        dp_n;
   logic        frame_pulse;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYC(G)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .dp_in       (dp_in),
      .load        (load),
      .blank       (blank),
      .x_out       (x_out),
      .an_n        (an_n),
      .dp_n        (dp_n),
      .frame_pulse (frame_pulse)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   int          t;
   logic [15:0] m_disp, m_pend;
   logic [3:0]  m_dpd, m_pdp;
   bit          m_pv;
   logic [3:0]  e_x, e_an;
   logic        e_dp, e_fp;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic bit lit(input int s);
`ifdef SEG_SCAN_LZB_EN
      int hi = -1;
      for (int i = 0; i < ND; i++) if (m_disp[i*4 +: 4] != 4'h0) hi = i;
      return (s == 0) || (s <= hi) || m_dpd[s];
`else
      return 1'b1;
`endif
   endfunction

   task automatic model_reset();
      t = 0;
      m_disp = '0; m_pend = '0; m_dpd = '0; m_pdp = '0; m_pv = 0;
      e_x = '0; e_an = 4'hF; e_dp = 1'b1; e_fp = 1'b0;
   endtask

   // One active edge with reset released: outputs come from the position
   // before the edge, then the buffers update.
   task automatic model_edge();
      int pos, s, c;
      pos = t % F;
      s   = pos / RD;
      c   = pos % RD;
      e_x  = m_disp[s*4 +: 4];
      e_an = (blank || c < G || !lit(s)) ? 4'hF : ~(4'b0001 << s);
      e_dp = blank ? 1'b1 : ~m_dpd[s];
      e_fp = (pos == F - 1);
      if (pos == F - 1) begin
         if (load) begin
            m_disp = value; m_dpd = dp_in;
         end else if (m_pv) begin
            m_disp = m_pend; m_dpd = m_pdp;
         end
         m_pv = 0;
      end else if (load) begin
         m_pend = value; m_pdp = dp_in; m_pv = 1;
      end
      t++;
   endtask

   // One clock: advance the model at the edge, compare on the falling edge.
   task automatic cyc();
      @(posedge clk);
      if (!rst_n) model_reset();
      else        model_edge();
      @(negedge clk);
      chk("x_out", 32'(x_out), 32'(e_x));
      chk("an_n", 32'(an_n), 32'(e_an));
      chk("dp_n", 32'(dp_n), 32'(e_dp));
      chk("frame_pulse", 32'(frame_pulse), 32'(e_fp));
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   // Advance until the next edge starts at frame position p (bounded).
   task automatic wait_pos(input int p);
      for (int k = 0; k < F + 1 && (t % F) != p; k++) cyc();
   endtask

   logic [3:0] exp_x[4];

   initial begin
      model_reset();
      exp_x[0] = 4'hF; exp_x[1] = 4'h3; exp_x[2] = 4'hA; exp_x[3] = 4'h1;

      // Reset state
      run(3);
      chk("rst_an_lit", 32'(an_n), 32'hF);
      chk("rst_x_lit", 32'(x_out), 32'h0);
      chk("rst_dp_lit", 32'(dp_n), 32'h1);
      chk("rst_fp_lit", 32'(frame_pulse), 32'h0);
      rst_n = 1'b1;

      // Idle scan with literal anode pattern pins
      for (int k = 1; k <= 40; k++) begin
         cyc();
         if (k == 2)  chk("idle_guard", 32'(an_n), 32'hF);
         if (k == 3)  chk("idle_s0", 32'(an_n), 32'hE);
         if (k == 11) chk("idle_s1", 32'(an_n), 32'hD);
         if (k == 19) chk("idle_s2", 32'(an_n), 32'hB);
         if (k == 27) chk("idle_s3", 32'(an_n), 32'h7);
         if (k == 31) chk("idle_fp_lo", 32'(frame_pulse), 32'h0);
         if (k == 32) chk("idle_fp_hi", 32'(frame_pulse), 32'h1);
         if (k == 33) chk("idle_wrap_guard", 32'(an_n), 32'hF);
      end

      // Mid-frame load: old digits finish, next frame shows F,3,A,1
      value = 16'h1A3F; dp_in = 4'b0100; load = 1'b1;
      cyc();
      load = 1'b0; value = '0; dp_in = '0;
      chk("old_frame_x", 32'(x_out), 32'h0);
      wait_pos(0);
      for (int s = 0; s < ND; s++) begin
         for (int c = 0; c < RD; c++) begin
            cyc();
            if (c == 4) begin
               chk("load_x_lit", 32'(x_out), 32'(exp_x[s]));
               chk("load_dp_lit", 32'(dp_n), (s == 2) ? 32'h0 : 32'h1);
            end
         end
      end

      // Two loads in one frame: last wins
      wait_pos(5);
      value = 16'h1111; load = 1'b1; cyc();
      value = 16'h0000; load = 1'b0; run(6);
      value = 16'h2222; load = 1'b1; cyc();
      value = 16'h0000; load = 1'b0;
      wait_pos(0);
      run(5);
      chk("last_load_wins", 32'(x_out), 32'h2);

      // Load coincident with the wrap terminal count
      wait_pos(F - 1);
      value = 16'h5555; load = 1'b1; cyc();
      load = 1'b0; value = '0;
      cyc();
      chk("wrap_load_x", 32'(x_out), 32'h5);
      run(F);

      // Blank for 10 cycles mid-slot
      wait_pos(RD + 3);
      blank = 1'b1;
      cyc();
      chk("blank_an", 32'(an_n), 32'hF);
      run(9);
      blank = 1'b0;
      run(20);

      // Asynchronous reset mid-slot 2
      wait_pos(2 * RD + 4);
      run(1);
      rst_n = 1'b0;
      #1;
      chk("arst_an", 32'(an_n), 32'hF);
      chk("arst_x", 32'(x_out), 32'h0);
      chk("arst_dp", 32'(dp_n), 32'h1);
      chk("arst_fp", 32'(frame_pulse), 32'h0);
      model_reset();
      run(2);
      rst_n = 1'b1;
      run(2);
      chk("post_rst_guard", 32'(an_n), 32'hF);
      cyc();
      chk("post_rst_s0", 32'(an_n), 32'hE);
      run(F);

      // Leading-zero scenarios
      value = 16'h0040; dp_in = '0; load = 1'b1; cyc();
      load = 1'b0;
      wait_pos(0);
      wait_pos(3 * RD + 4);
      cyc();
`ifdef SEG_SCAN_LZB_EN
      chk("lzb_d3", 32'(an_n), 32'hF);
`else
      chk("lzb_d3", 32'(an_n), 32'h7);
`endif
      wait_pos(RD + 4);
      cyc();
      chk("lzb_d1", 32'(an_n), 32'hD);
      value = 16'h0000; load = 1'b1; cyc();
      load = 1'b0;
      wait_pos(0);
      wait_pos(RD + 4);
      cyc();
`ifdef SEG_SCAN_LZB_EN
      chk("lzb_zero_d1", 32'(an_n), 32'hF);
`else
      chk("lzb_zero_d1", 32'(an_n), 32'hD);
`endif
      wait_pos(4);
      cyc();
      chk("lzb_zero_d0", 32'(an_n), 32'hE);

      // Randomized traffic
      for (int k = 0; k < 1500; k++) begin
         value = 16'($urandom);
         if ($urandom_range(3) == 0) value = value & 16'h00FF;
         dp_in = 4'($urandom);
         load  = ($urandom_range(15) == 0);
         if ($urandom_range(40) == 0) blank = ~blank;
         cyc();
      end
      load = 1'b0; blank = 1'b0;
      run(F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
